// File: rtl/lcd_timing_driver.sv
// RGB-LCD timing generator: HSYNC/VSYNC/DE, pixel request coordinates and
// DE-aligned RGB output for a pixel generator that registers its data one cycle.
module lcd_timing_driver #(
  parameter logic [10:0] H_SYNC  = 11'd41,
  parameter logic [10:0] H_BACK  = 11'd2,
  parameter logic [10:0] H_DISP  = 11'd480,
  parameter logic [10:0] H_FRONT = 11'd2,
  parameter logic [10:0] V_SYNC  = 11'd10,
  parameter logic [10:0] V_BACK  = 11'd2,
  parameter logic [10:0] V_DISP  = 11'd272,
  parameter logic [10:0] V_FRONT = 11'd2
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic [23:0] lcd_rgb,
  output logic        lcd_bl,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam logic [10:0] H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [10:0] V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [10:0] HA      = H_SYNC + H_BACK;
  localparam logic [10:0] VA      = V_SYNC + V_BACK;
  localparam logic [10:0] H_REQ   = HA - 11'd1;

  typedef enum logic {ST_RESET, ST_SCAN} state_t;

  state_t      state;
  logic [10:0] hc, vc;
  logic [10:0] hc_nxt, vc_nxt;
  logic        frame_wrap;
  logic        vact_nxt, de_nxt, req_nxt, origin_nxt;

  // Counters hold the position currently on the outputs; every output is
  // registered from the position about to be presented. Leaving reset
  // presents (0,0) rather than advancing.
  always_comb begin
    hc_nxt     = '0;
    vc_nxt     = '0;
    frame_wrap = 1'b0;
    if (state == ST_SCAN) begin
      if (hc == H_TOTAL - 11'd1) begin
        if (vc == V_TOTAL - 11'd1) begin
          frame_wrap = 1'b1;
        end else begin
          vc_nxt = vc + 11'd1;
        end
      end else begin
        hc_nxt = hc + 11'd1;
        vc_nxt = vc;
      end
    end
  end

  always_comb begin
    vact_nxt   = (vc_nxt >= VA) && (vc_nxt < VA + V_DISP);
    de_nxt     = vact_nxt && (hc_nxt >= HA) && (hc_nxt < HA + H_DISP);
    req_nxt    = vact_nxt && (hc_nxt >= H_REQ) && (hc_nxt < H_REQ + H_DISP);
    origin_nxt = (hc_nxt == '0) && (vc_nxt == '0);
  end

  always_ff @(posedge lcd_pclk) begin
    if (!rst_n) begin
      state       <= ST_RESET;
      hc          <= '0;
      vc          <= '0;
      frame_cnt   <= '0;
      lcd_hs      <= 1'b1;
      lcd_vs      <= 1'b1;
      lcd_de      <= 1'b0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      frame_start <= 1'b0;
      lcd_bl      <= 1'b0;
    end else begin
      state       <= ST_SCAN;
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      lcd_hs      <= !(hc_nxt < H_SYNC);
      lcd_vs      <= !(vc_nxt < V_SYNC);
      lcd_de      <= de_nxt;
      pixel_xpos  <= req_nxt ? hc_nxt - H_REQ : '0;
      pixel_ypos  <= vact_nxt ? vc_nxt - VA : '0;
      frame_start <= origin_nxt;
      lcd_bl      <= lcd_bl | origin_nxt;
      if (frame_wrap) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Generator data arrives registered one cycle after the request, i.e. on the DE cycle.
  assign lcd_rgb = lcd_de ? pixel_data : '0;
  assign h_disp  = H_DISP;
  assign v_disp  = V_DISP;

endmodule

// File: doc/lcd_timing_driver.md
Name: lcd_timing_driver

Overview:
- Generates RGB-LCD panel timing (HSYNC/VSYNC/DE), the current pixel coordinates and the panel resolution for the upstream pixel generator (lcd_display).
- Takes back that generator's registered pixel_data one cycle later and drives it onto the panel RGB bus, aligned to DE.
- Sits between the pixel generator and the LCD pins, in the lcd_pclk domain.

Parameters:
H_SYNC, 11'd41, HSYNC pulse width (pclk)
H_BACK, 11'd2, horizontal back porch
H_DISP, 11'd480, active pixels per line
H_FRONT, 11'd2, horizontal front porch
V_SYNC, 11'd10, VSYNC pulse width (lines)
V_BACK, 11'd2, vertical back porch
V_DISP, 11'd272, active lines per frame
V_FRONT, 11'd2, vertical front porch

Ports:
lcd_pclk  in  1  pixel clock, sole clock
rst_n  in  1  synchronous reset, active-low
pixel_data  in  24  RGB888 from the pixel generator, registered there one cycle after pixel_xpos/ypos
pixel_xpos  out  11  column being requested
pixel_ypos  out  11  row being requested
h_disp  out  11  constant H_DISP
v_disp  out  11  constant V_DISP
lcd_hs  out  1  HSYNC, active-low
lcd_vs  out  1  VSYNC, active-low
lcd_de  out  1  data enable, active-high
lcd_rgb  out  24  panel data
lcd_bl  out  1  backlight enable
frame_start  out  1  one-cycle pulse at the first pclk of each frame
frame_cnt  out  8  completed-frame counter

Behaviour:
- Constants: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters. HA = H_SYNC+H_BACK; VA = V_SYNC+V_BACK.
- Counters: hc runs 0..H_TOTAL-1 and wraps to 0. vc increments when hc wraps, runs 0..V_TOTAL-1, and wraps to 0 when hc and vc wrap together.
- Reset: all state is sampled on the lcd_pclk edge. While rst_n=0: hc=vc=0, frame_cnt=0, lcd_hs=1, lcd_vs=1, lcd_de=0, lcd_rgb=0, pixel_xpos=0, pixel_ypos=0, frame_start=0, lcd_bl=0.
- Reset released or asserted mid-frame: the first cycle after release presents position (0,0). Assertion mid-frame takes effect at the next edge; no partial-line recovery is needed.
- Output timing: all outputs are registered. Cycle n presents position (hc,vc)_n, and the first post-reset cycle presents (0,0).
  - lcd_hs = 0 iff hc < H_SYNC.
  - lcd_vs = 0 iff vc < V_SYNC.
  - vact = (VA <= vc < VA+V_DISP).
  - lcd_de = vact && (HA <= hc < HA+H_DISP).
  - req = vact && (HA-1 <= hc < HA-1+H_DISP).
  - pixel_xpos = req ? hc-(HA-1) : 0.
  - pixel_ypos = vact ? vc-VA : 0.
- Data alignment:
  - pixel_xpos=k is presented one cycle before the DE cycle of column k.
  - The generator registers pixel_data on that edge, so lcd_rgb = lcd_de ? pixel_data : 24'h0 (combinational mux on the input). Column k appears on the cycle lcd_de covers column k.
  - Fixed latency from xpos to rgb: 1 cycle.
- frame_start = 1 for exactly the cycle presenting (0,0), including the first cycle after reset.
- frame_cnt increments (mod 256) on each wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0). It wraps 255→0.
- lcd_bl = 1 from the first frame_start onward, until reset.
- h_disp and v_disp equal the parameters at all times, including during reset.
- Width rules: all position arithmetic is 11-bit unsigned. Parameters must satisfy HA >= 1, all totals <= 2047, and H_DISP, V_DISP >= 1. Violations are out of scope.

Test Plan:
- Reduced timing (H: 2/2/8/2, H_TOTAL=14; V: 1/1/4/1, V_TOTAL=7), hold reset 5 cycles, release -> during reset hs=vs=1, de=0, rgb=0, xpos=0, bl=0; first post-reset cycle frame_start=1, hs=0, vs=0, bl=1.
- Same config, line vc=2 -> hs=0 for hc 0..1; xpos = 0..7 on hc 3..10; de=1 exactly on hc 4..11; ypos=0 throughout.
- Drive pixel_data = {13'h0, xpos} registered one cycle (model generator) -> lcd_rgb equals 0..7 on the 8 DE cycles and 0 elsewhere; no off-by-one at hc 4 or 11.
- Full frame -> de high on vc 2..5 only; vs=0 only on vc=0; ypos 0..3; frame length 98 cycles between frame_start pulses; frame_cnt increments by 1 at each wrap.
- Run 256 frames -> frame_cnt wraps 255→0 coincident with frame_start.
- Assert rst_n=0 at hc=6, vc=3 for 2 cycles -> next edge returns all outputs to reset values; the cycle after release presents (0,0) with frame_start=1 and frame_cnt=0.
